// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU-op codes and the ID/EX control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Field order matches the 10-bit idex_ctrl bus, MSB first.
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic [1:0] aluOp;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch input, hazard/writeback sideband, register-file
// read port and the ID/EX register toward execute.
interface decode_stage_if;
    import mips_pkg::*;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        stall;
    logic        idex_valid;
    logic [31:0] idex_pc;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    ctrl_t       idex_ctrl;
    logic [31:0] idex_jtarget;

    // Surrounding pipeline / register file side.
    modport master (
        output if_valid, if_instr, if_pc, flush, ex_mem_read, ex_rd,
               wb_reg_write, wb_write_reg, wb_write_data, rf_read_data1, rf_read_data2,
        input  rf_read_reg1, rf_read_reg2, stall, idex_valid, idex_pc, idex_rs_data,
               idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd, idex_ctrl, idex_jtarget
    );

    // Decode stage side.
    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_mem_read, ex_rd,
               wb_reg_write, wb_write_reg, wb_write_data, rf_read_data1, rf_read_data2,
        output rf_read_reg1, rf_read_reg2, stall, idex_valid, idex_pc, idex_rs_data,
               idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd, idex_ctrl, idex_jtarget
    );

endinterface

// File: rtl/mips_control_decoder.sv
// Combinational opcode decoder: control word, destination register and
// whether the instruction reads rt as a source operand.
module mips_control_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic [4:0] destReg,
    output logic       readsRt
);

    // Opcode to control bits; a zero destination never writes.
    always_comb begin
        ctrl    = '0;
        destReg = '0;
        readsRt = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_FUNCT;
                destReg       = rd;
                readsRt       = 1'b1;
            end
            OP_LW: begin
                ctrl.regWrite = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_ADD;
                destReg       = rt;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_ADD;
                readsRt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluOp  = ALU_SUB;
                readsRt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_ADD;
                destReg       = rt;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (destReg == '0) begin
            ctrl.regWrite = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, register-file addressing, control decode,
// load-use stall detection and the ID/EX register.
// Optional feature: DECODE_WB_BYPASS_EN forwards same-cycle writeback data
// into the captured operands.
module decode_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);

    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    ctrl_t       decCtrl;
    logic [4:0]  destReg;
    logic        readsRt;
    logic        hazard;
    logic [31:0] pcPlus4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        unusedBits;

    assign rs               = ifidInstr[25:21];
    assign rt               = ifidInstr[20:16];
    assign bus.rf_read_reg1 = rs;
    assign bus.rf_read_reg2 = rt;
    assign pcPlus4          = ifidPc + 32'd4;

    mips_control_decoder u_dec (
        .opcode  (ifidInstr[31:26]),
        .rt      (rt),
        .rd      (ifidInstr[15:11]),
        .ctrl    (decCtrl),
        .destReg (destReg),
        .readsRt (readsRt)
    );

    assign hazard = ifidValid && bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == rs) || (readsRt && (bus.ex_rd == rt)));

    // A flush kills the IF/ID contents, so no hold is requested for them.
    assign bus.stall = hazard && !bus.flush;

`ifdef DECODE_WB_BYPASS_EN
    // Operand select: writeback data wins over the register file on a match.
    always_comb begin
        rsData = bus.rf_read_data1;
        rtData = bus.rf_read_data2;
        if (bus.wb_reg_write && (bus.wb_write_reg != '0) && (bus.wb_write_reg == rs)) begin
            rsData = bus.wb_write_data;
        end
        if (bus.wb_reg_write && (bus.wb_write_reg != '0) && (bus.wb_write_reg == rt)) begin
            rtData = bus.wb_write_data;
        end
    end
    assign unusedBits = ^pcPlus4[27:0];
`else
    assign rsData     = bus.rf_read_data1;
    assign rtData     = bus.rf_read_data2;
    assign unusedBits = ^{pcPlus4[27:0], bus.wb_reg_write, bus.wb_write_reg, bus.wb_write_data};
`endif

    // IF/ID register: reset > flush > stall hold > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifidValid <= 1'b0;
            ifidInstr <= '0;
            ifidPc    <= RESET_PC;
        end else if (bus.flush) begin
            ifidValid <= 1'b0;
        end else if (!hazard) begin
            ifidValid <= bus.if_valid;
            if (bus.if_valid) begin
                ifidInstr <= bus.if_instr;
                ifidPc    <= bus.if_pc;
            end
        end
    end

    // ID/EX register: data always follows decode, valid/ctrl become a bubble
    // on flush, stall or an empty IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.idex_valid   <= 1'b0;
            bus.idex_ctrl    <= '0;
            bus.idex_pc      <= RESET_PC;
            bus.idex_rs_data <= '0;
            bus.idex_rt_data <= '0;
            bus.idex_imm     <= '0;
            bus.idex_rs      <= '0;
            bus.idex_rt      <= '0;
            bus.idex_rd      <= '0;
            bus.idex_jtarget <= '0;
        end else begin
            bus.idex_pc      <= ifidPc;
            bus.idex_rs_data <= rsData;
            bus.idex_rt_data <= rtData;
            bus.idex_imm     <= {{16{ifidInstr[15]}}, ifidInstr[15:0]};
            bus.idex_rs      <= rs;
            bus.idex_rt      <= rt;
            bus.idex_rd      <= destReg;
            bus.idex_jtarget <= {pcPlus4[31:28], ifidInstr[25:0], 2'b00};
            if (bus.flush || hazard || !ifidValid) begin
                bus.idex_valid <= 1'b0;
                bus.idex_ctrl  <= '0;
            end else begin
                bus.idex_valid <= 1'b1;
                bus.idex_ctrl  <= decCtrl;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected ID/EX
// contents; a negedge monitor pops and compares whenever idex_valid is high.
module tb_decode_stage;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8CA1_0000; // lw   $1,0($5)
    localparam logic [31:0] I_ADDI = 32'h2020_FFFC; // addi $0,$1,-4
    localparam logic [31:0] I_ILL  = 32'hFC64_8000; // opcode 0x3F
    localparam logic [31:0] I_SW   = 32'hAC62_0004; // sw   $2,4($3)
    localparam logic [31:0] I_BEQ  = 32'h1022_FFFF; // beq  $1,$2,-1
    localparam logic [31:0] I_J    = 32'h0810_0040; // j
    localparam logic [31:0] I_ADDZ = 32'h0022_0020; // add  $0,$1,$2

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
        logic [31:0] jt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] regs [32];
    exp_t        sb [$];
    int          checks;
    int          errors;

    decode_stage_if bus ();

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register-file stand-in; deliberately never updated by writeback.
    assign bus.rf_read_data1 = regs[bus.rf_read_reg1];
    assign bus.rf_read_data2 = regs[bus.rf_read_reg2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, rsData, rtData, imm,
                                input logic [4:0] rs, rt, rd,
                                input logic [9:0] ctrl, input logic [31:0] jt);
        exp_t e;
        e.pc = pc; e.rsData = rsData; e.rtData = rtData; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl; e.jt = jt;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input bit push, input exp_t e);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        if (push) sb.push_back(e);
        step();
        bus.if_valid = 1'b0;
    endtask

    // Monitor: every valid ID/EX word must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.idex_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue got pc %h want none", bus.idex_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("idex_pc", bus.idex_pc, e.pc);
                chk("idex_rs_data", bus.idex_rs_data, e.rsData);
                chk("idex_rt_data", bus.idex_rt_data, e.rtData);
                chk("idex_imm", bus.idex_imm, e.imm);
                chk("idex_rs", {27'd0, bus.idex_rs}, {27'd0, e.rs});
                chk("idex_rt", {27'd0, bus.idex_rt}, {27'd0, e.rt});
                chk("idex_rd", {27'd0, bus.idex_rd}, {27'd0, e.rd});
                chk("idex_ctrl", {22'd0, bus.idex_ctrl}, {22'd0, e.ctrl});
                chk("idex_jtarget", bus.idex_jtarget, e.jt);
            end
        end
    end

    initial begin
        exp_t none;
        logic [31:0] bypassRs;
        none = mk('0, '0, '0, '0, '0, '0, '0, '0, '0);
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;

        reset             = 1'b1;
        bus.if_valid      = 1'b0;
        bus.if_instr      = '0;
        bus.if_pc         = '0;
        bus.flush         = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_rd         = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_write_reg  = '0;
        bus.wb_write_data = '0;
        repeat (2) step();

        chk("rst_idex_valid", {31'd0, bus.idex_valid}, 32'd0);
        chk("rst_idex_ctrl", {22'd0, bus.idex_ctrl}, 32'd0);
        chk("rst_idex_pc", bus.idex_pc, RST_PC);
        chk("rst_idex_rs_data", bus.idex_rs_data, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_rf_read_reg1", {27'd0, bus.rf_read_reg1}, 32'd0);
        reset = 1'b0;

        // Back-to-back stream covering every opcode class.
        issue(I_ADD,  32'h0000_0100, 1, mk(32'h100, 5, 7, 32'h1820, 1, 2, 3, 10'h204, 32'h0088_6080));
        issue(I_LW,   32'h0000_0200, 1, mk(32'h200, 32'hA000_0005, 5, 0, 5, 1, 1, 10'h360, 32'h0284_0000));
        issue(I_ADDI, 32'h0000_0500, 1, mk(32'h500, 5, 0, 32'hFFFF_FFFC, 1, 0, 0, 10'h020, 32'h0083_FFF0));
        issue(I_ILL,  32'h0000_0600, 1, mk(32'h600, 32'hA000_0003, 32'hA000_0004, 32'hFFFF_8000, 3, 4, 0, 10'h001, 32'h0192_0000));
        issue(I_SW,   32'h0000_0700, 1, mk(32'h700, 32'hA000_0003, 7, 4, 3, 2, 0, 10'h0A0, 32'h0188_0010));
        issue(I_BEQ,  32'h0000_0800, 1, mk(32'h800, 5, 7, 32'hFFFF_FFFF, 1, 2, 0, 10'h012, 32'h008B_FFFC));
        issue(I_J,    32'h9000_0800, 1, mk(32'h9000_0800, 0, 32'hA000_0010, 32'h40, 0, 16, 0, 10'h008, 32'h9040_0100));
        issue(I_ADDZ, 32'h0000_0A00, 1, mk(32'hA00, 5, 7, 32'h20, 1, 2, 0, 10'h004, 32'h0088_0080));
        repeat (2) step();

        // Load-use against an R-type in IF/ID.
        issue(I_ADD, 32'h0000_0300, 1, mk(32'h300, 5, 7, 32'h1820, 1, 2, 3, 10'h204, 32'h0088_6080));
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1; #1 chk("stall_rs", {31'd0, bus.stall}, 32'd1);
        bus.ex_rd = 5'd2; #1 chk("stall_rt_rtype", {31'd0, bus.stall}, 32'd1);
        bus.ex_rd = 5'd3; #1 chk("nostall_other", {31'd0, bus.stall}, 32'd0);
        bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd1; #1 chk("nostall_noload", {31'd0, bus.stall}, 32'd0);
        bus.ex_mem_read = 1'b1;
        step();
        chk("stall_bubble_valid", {31'd0, bus.idex_valid}, 32'd0);
        chk("stall_bubble_ctrl", {22'd0, bus.idex_ctrl}, 32'd0);
        chk("stall_hold_reg1", {27'd0, bus.rf_read_reg1}, 32'd1);
        chk("stall_hold_reg2", {27'd0, bus.rf_read_reg2}, 32'd2);
        chk("stall_persist", {31'd0, bus.stall}, 32'd1);
        bus.ex_mem_read = 1'b0;
        #1 chk("stall_release", {31'd0, bus.stall}, 32'd0);
        step();

        // lw does not read rt, so a match on rt alone is harmless.
        issue(I_LW, 32'h0000_0340, 1, mk(32'h340, 32'hA000_0005, 5, 0, 5, 1, 1, 10'h360, 32'h0284_0000));
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1; #1 chk("nostall_lw_rt", {31'd0, bus.stall}, 32'd0);
        bus.ex_rd = 5'd5; #1 chk("stall_lw_rs", {31'd0, bus.stall}, 32'd1);
        bus.ex_mem_read = 1'b0;
        repeat (2) step();

        // Flush coinciding with a load-use hazard.
        issue(I_ADD, 32'h0000_0400, 0, none);
        bus.flush = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
        bus.if_valid = 1'b1; bus.if_instr = I_ADDI; bus.if_pc = 32'h0000_0404;
        #1 chk("flush_stall_masked", {31'd0, bus.stall}, 32'd0);
        step();
        chk("flush_idex_valid", {31'd0, bus.idex_valid}, 32'd0);
        chk("flush_idex_ctrl", {22'd0, bus.idex_ctrl}, 32'd0);
        bus.flush = 1'b0; bus.if_valid = 1'b0;
        #1 chk("flush_ifid_invalid", {31'd0, bus.stall}, 32'd0);
        step();
        chk("flush_idex_valid2", {31'd0, bus.idex_valid}, 32'd0);
        bus.ex_mem_read = 1'b0;

        // Same-cycle writeback to rs while the register file is stale.
`ifdef DECODE_WB_BYPASS_EN
        bypassRs = 32'h0000_DEAD;
`else
        bypassRs = 32'd5;
`endif
        issue(I_ADD, 32'h0000_0480, 1, mk(32'h480, bypassRs, 7, 32'h1820, 1, 2, 3, 10'h204, 32'h0088_6080));
        bus.wb_reg_write = 1'b1; bus.wb_write_reg = 5'd1; bus.wb_write_data = 32'h0000_DEAD;
        step();
        bus.wb_reg_write = 1'b0; bus.wb_write_reg = '0; bus.wb_write_data = '0;

        // Reset mid-stream with an instruction in IF/ID and a pending load-use.
        issue(I_ADD, 32'h0000_04C0, 0, none);
        reset = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_idex_valid", {31'd0, bus.idex_valid}, 32'd0);
        chk("mid_rst_idex_ctrl", {22'd0, bus.idex_ctrl}, 32'd0);
        chk("mid_rst_idex_pc", bus.idex_pc, RST_PC);
        chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        bus.ex_mem_read = 1'b0; bus.ex_rd = '0;

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
